// File: rtl/sd_bitstream_decoder.sv
// sd_bitstream_decoder: sinc2 CIC decimator turning a 1-bit sigma-delta stream into a raw and a 4-bit signed estimate
// Ports:
//   clck         system clock, rising edge
//   rst          asynchronous active-high reset
//   bit_in       modulator bit (1 -> +1, 0 -> -1)
//   bit_en       bit strobe; bit_in consumed only when high
//   sample_raw   signed CIC output, range [-R^2, +R^2]
//   x_est        signed 4-bit estimate, range [-8, 7]
//   x_sat        x_est was clamped for the current sample
//   sample_valid one-cycle pulse when a settled sample is loaded
module sd_bitstream_decoder #(
  parameter int LOG2_R = 4,
  parameter int W      = 2*LOG2_R+2
) (
  input  logic                clck,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_en,
  output logic signed [W-1:0] sample_raw,
  output logic signed [3:0]   x_est,
  output logic                x_sat,
  output logic                sample_valid
);
  localparam int SH = 2*LOG2_R-3;
  localparam logic signed [W:0] RND = (W+1)'(1) << (2*LOG2_R-4);
  logic signed [W-1:0] int1, int2, z1, z2, int1_n, int2_n, c1, c2;
  logic signed [W:0] c2x, t;
  logic [LOG2_R-1:0] ph;
  logic [1:0] prime;
  logic dec, sat_hi, sat_lo;
  always_comb begin
    int1_n = int1 + (bit_in ? W'(1) : {W{1'b1}});
    int2_n = int2 + int1_n;
    dec    = bit_en && (ph == {LOG2_R{1'b1}});
    c1     = int2_n - z1;
    c2     = c1 - z2;
    // widen by one bit so the rounding add cannot overflow
    c2x    = {c2[W-1], c2} + RND;
    t      = c2x >>> SH;
    sat_hi = t > 7;
    sat_lo = t < -8;
  end
  always_ff @(posedge clck or posedge rst)
    if (rst) begin
      int1         <= '0;
      int2         <= '0;
      z1           <= '0;
      z2           <= '0;
      ph           <= '0;
      prime        <= '0;
      sample_raw   <= '0;
      x_est        <= '0;
      x_sat        <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (bit_en) begin
        int1 <= int1_n;
        int2 <= int2_n;
        ph   <= ph + LOG2_R'(1);
      end
      if (dec) begin
        z1    <= int2_n;
        z2    <= c1;
        prime <= (prime == 2'd2) ? prime : prime + 2'd1;
        // the first frame after reset only fills the comb delays
        if (prime != 2'd0) begin
          sample_raw   <= c2;
          x_est        <= sat_hi ? 4'sd7 : sat_lo ? -4'sd8 : t[3:0];
          x_sat        <= sat_hi || sat_lo;
          sample_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sd_bitstream_decoder.sv
// tb_sd_bitstream_decoder: randomized and directed check of the decoder against a sinc2 convolution model
module tb_sd_bitstream_decoder;
  localparam int LOG2_R = 4;
  localparam int R = 1 << LOG2_R;
  localparam int W = 2*LOG2_R+2;
  logic clk = 1'b0, rst = 1'b0, bit_in = 1'b0, bit_en = 1'b0;
  logic signed [W-1:0] sample_raw;
  logic signed [3:0] x_est;
  logic x_sat, sample_valid;
  int checks = 0, errors = 0;
  int q[$];
  int e_raw = 0, e_x = 0, e_sat = 0;
  always #5 clk = ~clk;
  sd_bitstream_decoder #(.LOG2_R(LOG2_R)) dut (
    .clck(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .sample_raw(sample_raw), .x_est(x_est), .x_sat(x_sat), .sample_valid(sample_valid)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // sinc2 = triangular FIR of length 2R-1 over the last consumed bits
  function automatic int cic();
    int s = 0;
    int n = q.size();
    for (int j = 0; j < 2*R; j++) s += (q[n-1-j] != 0 ? 1 : -1) * (j < R ? j+1 : 2*R-1-j);
    return s;
  endfunction
  function automatic int scale(input int c);
    int div = 1 << (2*LOG2_R-3);
    return (c + div/2 + div*4096) / div - 4096;
  endfunction
  task automatic check_out(input string tag, input int v);
    check({tag, ".valid"}, sample_valid, v);
    check({tag, ".raw"}, sample_raw, e_raw);
    check({tag, ".x_est"}, x_est, e_x);
    check({tag, ".x_sat"}, x_sat, e_sat);
  endtask
  task automatic step(input string tag, input bit b, input bit en);
    int v = 0;
    int t;
    @(negedge clk);
    bit_in = b;
    bit_en = en;
    if (en) begin
      q.push_back(b);
      if (q.size() % R == 0 && q.size() >= 2*R) begin
        v = 1;
        e_raw = cic();
        t = scale(e_raw);
        e_sat = (t > 7 || t < -8) ? 1 : 0;
        e_x = t > 7 ? 7 : t < -8 ? -8 : t;
      end
    end
    @(posedge clk);
    #1;
    check_out(tag, v);
  endtask
  // reset lands between clock edges so only an asynchronous clear passes
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bit_en = 1'b0;
    q.delete();
    e_raw = 0;
    e_x = 0;
    e_sat = 0;
    #1;
    check_out(tag, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    do_reset("rst0");
    for (int i = 0; i < 64; i++) step("ones", 1'b1, 1'b1);
    do_reset("rst1");
    for (int i = 0; i < 64; i++) step("zeros", 1'b0, 1'b1);
    do_reset("rst2");
    for (int i = 0; i < 64; i++) step("alt", i % 2 == 0, 1'b1);
    do_reset("rst3");
    for (int i = 0; i < 64; i++) step("p1110", i % 4 != 3, 1'b1);
    do_reset("rst4");
    for (int i = 0; i < 192; i++) step("p1110_sparse", (i/3) % 4 != 3, i % 3 == 0);
    do_reset("rst5");
    for (int i = 0; i < 1100; i++) step("wrap", 1'b1, 1'b1);
    do_reset("rst6");
    for (int i = 0; i < 40; i++) step("pre_rst", 1'b1, 1'b1);
    do_reset("mid_rst");
    for (int i = 0; i < 48; i++) step("post_rst", 1'b1, 1'b1);
    do_reset("rst7");
    for (int i = 0; i < 800; i++) step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_bitstream_decoder.md
Name: sd_bitstream_decoder

Overview:
- Receive-side counterpart of the MASH sigma-delta modulator: takes the modulator's 1-bit output stream and reconstructs a multi-bit signed estimate of the original input.
- Filters and decimates with a 2nd-order CIC (sinc2), decimation ratio R = 2^LOG2_R.
- Produces a raw CIC value and a 4-bit estimate on the same scale as the modulator's 4-bit signed input. Used in loopback testing against the modulator and feeds the 7-segment display logic.

Parameters:
- LOG2_R, 4, log2 of the decimation ratio R. Legal range 2..8.
- W, 2*LOG2_R+2, internal/raw width in bits (signed, two's complement). Derived; do not override.

Ports:
- clck  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  modulator bitstream bit. 1 maps to +1, 0 maps to -1.
- bit_en  in  1  bit strobe. bit_in is consumed only on edges where bit_en=1.
- sample_raw  out  W  signed CIC output, range [-R^2, +R^2].
- x_est  out  4  signed estimate, range [-8, 7].
- x_sat  out  1  high when x_est was clamped for the current sample.
- sample_valid  out  1  one-cycle pulse when the output registers update with a settled sample.

Behaviour:
- Reset (async, rst=1): int1, int2, z1, z2, phase counter ph, prime counter all clear to 0. sample_raw=0, x_est=0, x_sat=0, sample_valid=0. Reset takes effect immediately, including mid-frame. After release, the decoder re-primes from scratch.
- bit_en=0: all state holds. sample_valid=0.
- bit_en=1, per edge:
  - d = bit_in ? +1 : -1.
  - int1_n = int1 + d; int2_n = int2 + int1_n (integrator 2 uses the updated int1).
  - Register int1 <= int1_n, int2 <= int2_n.
  - All integrator arithmetic is modulo 2^W. Wrap-around is intentional and is cancelled by the combs; no saturation in the integrators.
  - ph increments modulo R.
- Decimation event (bit_en=1 and ph==R-1):
  - c1 = int2_n - z1; z1 <= int2_n.
  - c2 = c1 - z2; z2 <= c1.
  - Comb arithmetic is W-bit modulo.
- Prime counter (0..2, saturates at 2) increments on each decimation event.
  - First decimation after reset: partially filled, so no sample_valid and outputs unchanged.
  - Second and later decimations: sample_raw <= c2, x_est/x_sat updated, sample_valid=1 for exactly the next cycle.
- Latency: sample_valid is high in the cycle following the edge that consumed the R-th bit of the frame.
- Scaling:
  - t = (c2 + 2^(2*LOG2_R-4)) >>> (2*LOG2_R-3), arithmetic shift with round-half-up.
  - If t > 7: x_est=7, x_sat=1. If t < -8: x_est=-8, x_sat=1. Otherwise x_est=t[3:0], x_sat=0.
  - Compute t at W+1 bits so the rounding add cannot overflow.
- sample_raw, x_est and x_sat hold between valid pulses.
- bit_en may be asserted on consecutive cycles or sparsely. Results depend only on the sequence of consumed bits, not on the gaps between them.

Test Plan:
- Reset then 64 bits of 1, bit_en every cycle, LOG2_R=4: no pulse after the 16th bit. Pulses after bits 32, 48 and 64, each with sample_raw=256, x_est=7, x_sat=1.
- 64 bits of 0: settled sample_raw=-256, x_est=-8, x_sat=1 on every valid pulse.
- Alternating 1,0 for 64 bits: sample_raw=0, x_est=0, x_sat=0 from the second decimation onward.
- Repeating pattern 1,1,1,0: sample_raw=128, x_est=4. Repeat with bit_en high only every 3rd cycle: identical values, pulses spaced 48 cycles apart.
- Long run of 1s (>= 2^W bits, integrator wrap): sample_raw stays 256 on every pulse.
- Assert rst after bit 40 of a 1s stream, release, then continue 1s: outputs go to 0 immediately. No pulse at post-reset bit 16. First pulse at post-reset bit 32 with sample_raw=256.
